// File: rtl/memory_read_guard.sv
// memory_read_guard
// -----------------------------------------------------------------------------
// Access-control front end for the memory read path. Up to four requesters
// issue reads tagged with a 2-bit module ID. Each request is checked against
// two authorized regions (module ID + addr[3:2] tag) and the per-ID lock bit.
// Authorized reads go to memory through a req/ack handshake. Denied reads are
// blocked, raise an alert and count toward a per-ID lockout. Memory that does
// not answer within MEM_TIMEOUT cycles ends the read with timeout_err.
//
// Every output is registered. It reflects the state of the previous cycle, so
// a denied read completes in the cycle after the second edge following the
// request sample.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rd_req/rd_addr/rd_module_id   requester side request
//   rd_ack/rd_denied/rd_data      requester side completion (one-cycle)
//   mem_req/mem_addr/mem_ack/mem_data  memory read port handshake
//   alert/alert_module_id/alert_addr   unauthorized-read report
//   timeout_err          one-cycle pulse when memory did not respond
//   lock_status          per-module-ID lock bits
//   lock_clear           synchronous clear of all lock bits and counters
//
// Build option:
//   STICKY_ALERT_EN  defined: alert and its ID/address hold the first
//                    violation until lock_clear.
//                    undefined (default): alert is a one-cycle pulse.
// -----------------------------------------------------------------------------
module memory_read_guard #(
  parameter logic [1:0]  REGION0_ID     = 2'b01,
  parameter logic [1:0]  REGION0_TAG    = 2'b10,
  parameter logic [1:0]  REGION1_ID     = 2'b10,
  parameter logic [1:0]  REGION1_TAG    = 2'b11,
  parameter int unsigned LOCK_THRESHOLD = 3,
  parameter int unsigned MEM_TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_req,
  input  logic [3:0] rd_addr,
  input  logic [1:0] rd_module_id,
  output logic       rd_ack,
  output logic       rd_denied,
  output logic [3:0] rd_data,
  output logic       mem_req,
  output logic [3:0] mem_addr,
  input  logic       mem_ack,
  input  logic [3:0] mem_data,
  output logic       alert,
  output logic [1:0] alert_module_id,
  output logic [3:0] alert_addr,
  output logic       timeout_err,
  output logic [3:0] lock_status,
  input  logic       lock_clear
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] MEM_WAIT = 3'd2;
  localparam logic [2:0] RESPOND  = 3'd3;
  localparam logic [2:0] BLOCK    = 3'd4;
  localparam logic [2:0] TMO      = 3'd5;

  localparam logic [7:0] TMO_LIMIT  = 8'(MEM_TIMEOUT);
  localparam logic [1:0] LOCK_LIMIT = 2'(LOCK_THRESHOLD);

  // Region table lookup; lock bits are applied separately.
  function automatic logic region_ok(input logic [1:0] id, input logic [1:0] tag);
    region_ok = ((id == REGION0_ID) && (tag == REGION0_TAG)) ||
                ((id == REGION1_ID) && (tag == REGION1_TAG));
  endfunction

  logic [2:0]      state_q, state_d;
  logic [3:0]      addr_q, addr_d;
  logic [1:0]      id_q, id_d;
  logic [3:0]      data_q, data_d;
  logic [7:0]      timer_q, timer_d;
  logic [3:0][1:0] cnt_q, cnt_d;
  logic [3:0]      lock_q, lock_d;
  logic [1:0]      cnt_inc_s;

  logic       rd_ack_q, rd_ack_d;
  logic       rd_denied_q, rd_denied_d;
  logic [3:0] rd_data_q, rd_data_d;
  logic       mem_req_q, mem_req_d;
  logic [3:0] mem_addr_q, mem_addr_d;
  logic       alert_q, alert_d;
  logic [1:0] alert_id_q, alert_id_d;
  logic [3:0] alert_addr_q, alert_addr_d;
  logic       tmo_err_q, tmo_err_d;

  // Transaction FSM: next state, request latches, memory data and wait timer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    data_d  = data_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_d  = rd_addr;
          id_d    = rd_module_id;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (region_ok(id_q, addr_q[3:2]) && !lock_q[id_q]) begin
          timer_d = 8'd0;
          state_d = MEM_WAIT;
        end else begin
          state_d = BLOCK;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          data_d  = mem_data;
          state_d = RESPOND;
        end else begin
          // timer counts completed unanswered cycles; the limit-th one ends the wait
          timer_d = timer_q + 8'd1;
          if (timer_d == TMO_LIMIT) begin
            state_d = TMO;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      RESPOND: state_d = IDLE;
      BLOCK:   state_d = IDLE;
      TMO:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Violation counters and lock bits; lock_clear takes priority over a BLOCK update.
  always_comb begin
    cnt_d     = cnt_q;
    lock_d    = lock_q;
    cnt_inc_s = 2'd0;
    if (lock_clear) begin
      cnt_d  = '0;
      lock_d = 4'b0000;
    end else if (state_q == BLOCK) begin
      cnt_inc_s   = (cnt_q[id_q] == 2'd3) ? 2'd3 : (cnt_q[id_q] + 2'd1);
      cnt_d[id_q] = cnt_inc_s;
      if (cnt_inc_s >= LOCK_LIMIT) begin
        lock_d[id_q] = 1'b1;
      end else begin
        lock_d[id_q] = lock_q[id_q];
      end
    end else begin
      cnt_d  = cnt_q;
      lock_d = lock_q;
    end
  end

  // Registered output values derived from the current state.
  always_comb begin
    rd_ack_d    = (state_q == RESPOND) || (state_q == BLOCK) || (state_q == TMO);
    rd_denied_d = (state_q == BLOCK) || (state_q == TMO);
    rd_data_d   = (state_q == RESPOND) ? data_q : 4'h0;
    tmo_err_d   = (state_q == TMO);
    // mem_req is aligned with the MEM_WAIT state itself
    mem_req_d   = (state_d == MEM_WAIT);
    mem_addr_d  = mem_req_d ? addr_d : 4'h0;
`ifdef STICKY_ALERT_EN
    alert_d      = alert_q;
    alert_id_d   = alert_id_q;
    alert_addr_d = alert_addr_q;
    if (lock_clear) begin
      alert_d      = 1'b0;
      alert_id_d   = 2'd0;
      alert_addr_d = 4'h0;
    end else if ((state_q == BLOCK) && !alert_q) begin
      alert_d      = 1'b1;
      alert_id_d   = id_q;
      alert_addr_d = addr_q;
    end else begin
      alert_d      = alert_q;
    end
`else
    alert_d      = (state_q == BLOCK);
    alert_id_d   = (state_q == BLOCK) ? id_q : 2'd0;
    alert_addr_d = (state_q == BLOCK) ? addr_q : 4'h0;
`endif
  end

  // State, latches, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= 4'h0;
      id_q         <= 2'd0;
      data_q       <= 4'h0;
      timer_q      <= 8'd0;
      cnt_q        <= '0;
      lock_q       <= 4'b0000;
      rd_ack_q     <= 1'b0;
      rd_denied_q  <= 1'b0;
      rd_data_q    <= 4'h0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 4'h0;
      alert_q      <= 1'b0;
      alert_id_q   <= 2'd0;
      alert_addr_q <= 4'h0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      lock_q       <= lock_d;
      rd_ack_q     <= rd_ack_d;
      rd_denied_q  <= rd_denied_d;
      rd_data_q    <= rd_data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      alert_q      <= alert_d;
      alert_id_q   <= alert_id_d;
      alert_addr_q <= alert_addr_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign rd_ack          = rd_ack_q;
  assign rd_denied       = rd_denied_q;
  assign rd_data         = rd_data_q;
  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;
  assign alert           = alert_q;
  assign alert_module_id = alert_id_q;
  assign alert_addr      = alert_addr_q;
  assign timeout_err     = tmo_err_q;
  assign lock_status     = lock_q;

endmodule

// File: tb/tb_memory_read_guard.sv
// Testbench for memory_read_guard (default build, STICKY_ALERT_EN undefined).
// Requests push their hand-computed completion into a queue; a monitor pops
// and compares whenever rd_ack is presented. A small memory responder answers
// mem_req after a programmed delay and checks mem_addr.
module tb_memory_read_guard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic [1:0] rd_module_id = 2'd0;
  logic       rd_ack, rd_denied, mem_req, alert, timeout_err;
  logic [3:0] rd_data, mem_addr, alert_addr, lock_status;
  logic [1:0] alert_module_id;
  logic       mem_ack = 1'b0;
  logic [3:0] mem_data = 4'h0;
  logic       lock_clear = 1'b0;

  memory_read_guard dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_module_id(rd_module_id),
    .rd_ack(rd_ack), .rd_denied(rd_denied), .rd_data(rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .alert(alert), .alert_module_id(alert_module_id), .alert_addr(alert_addr),
    .timeout_err(timeout_err), .lock_status(lock_status), .lock_clear(lock_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       denied;
    logic [3:0] data;
    logic       alert;
    logic [1:0] aid;
    logic [3:0] aaddr;
    logic       tmo;
    logic [3:0] lock;
    logic       mem_used;
    int         lat;
    int         t0;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mem_dly = -1;
  int         mem_cnt = 0;
  logic [3:0] mem_val = 4'h0;
  logic [3:0] cur_addr = 4'h0;
  logic       mem_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic den, input logic [3:0] dat, input logic al,
                              input logic [1:0] aid, input logic [3:0] aad, input logic tmo,
                              input logic [3:0] lk, input logic mu, input int lat);
    exp_t e;
    e.denied = den; e.data = dat; e.alert = al; e.aid = aid; e.aaddr = aad;
    e.tmo = tmo; e.lock = lk; e.mem_used = mu; e.lat = lat; e.t0 = 0;
    return e;
  endfunction

  // Memory responder: ack after mem_dly cycles of mem_req (never if negative).
  always @(negedge clk) begin
    if (rst_n && mem_req) begin
      mem_seen = 1'b1;
      chk("mem_addr", {28'd0, mem_addr}, {28'd0, cur_addr});
      if (mem_cnt == mem_dly) begin
        mem_ack  = 1'b1;
        mem_data = mem_val;
      end else begin
        mem_ack  = 1'b0;
        mem_data = 4'h0;
      end
      mem_cnt = mem_cnt + 1;
    end else begin
      mem_ack  = 1'b0;
      mem_data = 4'h0;
      mem_cnt  = 0;
    end
  end

  // Monitor: compare every completion against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_ack) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rd_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rd_denied", {31'd0, rd_denied}, {31'd0, e.denied});
        chk("rd_data", {28'd0, rd_data}, {28'd0, e.data});
        chk("alert", {31'd0, alert}, {31'd0, e.alert});
        chk("alert_module_id", {30'd0, alert_module_id}, {30'd0, e.aid});
        chk("alert_addr", {28'd0, alert_addr}, {28'd0, e.aaddr});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.tmo});
        chk("lock_status", {28'd0, lock_status}, {28'd0, e.lock});
        chk("mem_req_used", {31'd0, mem_seen}, {31'd0, e.mem_used});
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] id, input logic [3:0] addr, input int dly,
                       input logic [3:0] val, input exp_t e_in);
    exp_t e;
    bit   done;
    e = e_in;
    @(negedge clk);
    mem_seen     = 1'b0;
    mem_dly      = dly;
    mem_val      = val;
    cur_addr     = addr;
    rd_req       = 1'b1;
    rd_addr      = addr;
    rd_module_id = id;
    e.t0         = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
    done   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk("rd_ack_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    lock_clear = 1'b1;
    @(negedge clk);
    lock_clear = 1'b0;
    chk("lock_after_clear", {28'd0, lock_status}, 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {5'd0, rd_ack, rd_denied, rd_data, mem_req, mem_addr, alert,
               alert_module_id, alert_addr, timeout_err, lock_status}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // Authorized read, ack 2 cycles into MEM_WAIT
    issue(2'd1, 4'hA, 2, 4'h5, mk(1'b0, 4'h5, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 1'b1, 6));
    // Wrong region for id 1
    issue(2'd1, 4'hC, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd1, 4'hC, 1'b0, 4'h0, 1'b0, 3));
    // id 3 is never authorized: third violation locks it
    issue(2'd3, 4'h0, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd3, 4'h0, 1'b0, 4'h0, 1'b0, 3));
    issue(2'd3, 4'h4, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd3, 4'h4, 1'b0, 4'h0, 1'b0, 3));
    issue(2'd3, 4'h8, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd3, 4'h8, 1'b0, 4'h8, 1'b0, 3));
    do_clear();
    // Region 1 read with immediate ack
    issue(2'd2, 4'hD, 0, 4'h9, mk(1'b0, 4'h9, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 1'b1, 4));
    // Lock id 2, then its own region is blocked
    issue(2'd2, 4'h0, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd2, 4'h0, 1'b0, 4'h0, 1'b0, 3));
    issue(2'd2, 4'h4, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd2, 4'h4, 1'b0, 4'h0, 1'b0, 3));
    issue(2'd2, 4'h8, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd2, 4'h8, 1'b0, 4'h4, 1'b0, 3));
    issue(2'd2, 4'hC, 0, 4'h7, mk(1'b1, 4'h0, 1'b1, 2'd2, 4'hC, 1'b0, 4'h4, 1'b0, 3));
    do_clear();
    issue(2'd1, 4'hB, 1, 4'hF, mk(1'b0, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 1'b1, 5));
    issue(2'd1, 4'hC, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd1, 4'hC, 1'b0, 4'h0, 1'b0, 3));
    // Timeout does not count as a violation: lock needs two more denials
    issue(2'd1, 4'h8, -1, 4'h0, mk(1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 1'b1, 18));
    issue(2'd1, 4'h0, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd1, 4'h0, 1'b0, 4'h0, 1'b0, 3));
    issue(2'd1, 4'h4, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd1, 4'h4, 1'b0, 4'h2, 1'b0, 3));
    issue(2'd0, 4'h8, -1, 4'h0, mk(1'b1, 4'h0, 1'b1, 2'd0, 4'h8, 1'b0, 4'h2, 1'b0, 3));

    // Reset in the middle of MEM_WAIT
    @(negedge clk);
    mem_dly      = -1;
    cur_addr     = 4'hE;
    rd_req       = 1'b1;
    rd_addr      = 4'hE;
    rd_module_id = 2'd2;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mem_req_before_reset", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("mem_req_async_drop", {31'd0, mem_req}, 32'd0);
    chk_all_zero("outputs_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("outputs_after_reset");
    sb_q.delete();
    issue(2'd2, 4'hC, 0, 4'h3, mk(1'b0, 4'h3, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 1'b1, 4));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
